// File: rtl/ysyx_22051013_ifu_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_22051013_ifu_pkg
//
// Purpose: shared definitions for the instruction-fetch unit.
//   - RV64 opcode constants that the fetch predecoder recognises (JAL, BRANCH)
//   - default reset fetch address
//   - sequential-fetch increment (YSYX_22051013_PLUS4)
//   - fetch FSM state encoding
//   - align_pc(): clears bits [1:0] of a PC
//
// Optional feature macro used by the fetch unit: YSYX_22051013_BPU_EN
// (static backward-taken branch prediction, see ysyx_22051013_ifu_predecode).
// ----------------------------------------------------------------------------
package ysyx_22051013_ifu_pkg;

    // Major opcodes inspected by the predecoder.
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // First fetch address after reset.
    localparam logic [63:0] IFU_RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

    // Sequential fetch increment (one 32-bit instruction).
    localparam logic [63:0] YSYX_22051013_PLUS4 = 64'd4;

    // Fetch FSM states.
    //   ST_RST   : one cycle after reset release, no request yet
    //   ST_REQ   : request presented to instruction memory
    //   ST_WAIT  : request accepted, waiting for the response
    //   ST_VALID : instruction presented to decode
    //   ST_DROP  : response still outstanding but already known to be wrong-path
    typedef enum logic [2:0] {
        ST_RST   = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_VALID = 3'd3,
        ST_DROP  = 3'd4
    } ifu_state_e;

    // Every PC held or produced by the fetch unit is word aligned.
    function automatic logic [63:0] align_pc(input logic [63:0] pc);
        return {pc[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/ysyx_22051013_ifu_predecode.sv
// ----------------------------------------------------------------------------
// ysyx_22051013_ifu_predecode
//
// Purpose: purely combinational predecode of a fetched instruction word to
// produce the predicted next fetch PC.
//   - JAL     : pc + sext(J-imm); not flagged as a predicted branch, since
//               decode never resolves JAL and must not redirect for it.
//   - BRANCH  : with YSYX_22051013_BPU_EN defined, backward branches
//               (imm[12]=1) are predicted taken (pc + sext(B-imm), bpu_jump=1)
//               and forward branches fall through (pc+4). Without the macro
//               every branch falls through and bpu_jump is tied 0.
//   - other   : pc + 4.
// All results are word aligned; arithmetic wraps at 64 bits.
//
// Ports:
//   inst     in  32  instruction word
//   pc       in  64  PC of inst
//   next_pc  out 64  predicted next fetch PC
//   bpu_jump out 1   inst is a branch predicted taken
// ----------------------------------------------------------------------------
module ysyx_22051013_ifu_predecode
    import ysyx_22051013_ifu_pkg::*;
(
    input  logic [31:0] inst,
    input  logic [63:0] pc,
    output logic [63:0] next_pc,
    output logic        bpu_jump
);

    logic [6:0]  opcode;
    logic [63:0] j_imm;
    logic [63:0] pc_plus4;
    logic [63:0] pc_jal;

    assign opcode   = inst[6:0];
    // J-type immediate: imm[20|10:1|11|19:12] in inst[31:12], imm[0]=0.
    assign j_imm    = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign pc_plus4 = pc + YSYX_22051013_PLUS4;
    assign pc_jal   = pc + j_imm;

`ifdef YSYX_22051013_BPU_EN
    logic [63:0] b_imm;
    logic [63:0] pc_branch;

    // B-type immediate: imm[12|10:5] in inst[31:25], imm[4:1|11] in inst[11:7].
    assign b_imm     = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign pc_branch = pc + b_imm;

    always_comb begin
        next_pc  = align_pc(pc_plus4);
        bpu_jump = 1'b0;
        if (opcode == OPC_JAL) begin
            next_pc = align_pc(pc_jal);
        end else if ((opcode == OPC_BRANCH) && inst[31]) begin
            // inst[31] is the immediate sign bit: backward branches are
            // usually loop back-edges, so predict them taken.
            next_pc  = align_pc(pc_branch);
            bpu_jump = 1'b1;
        end
    end
`else
    // rd / B-imm low field bits are only needed when branch prediction is on.
    logic unused_inst_bits;
    assign unused_inst_bits = ^inst[11:7];

    always_comb begin
        next_pc  = align_pc(pc_plus4);
        bpu_jump = 1'b0;
        if (opcode == OPC_JAL) begin
            next_pc = align_pc(pc_jal);
        end
    end
`endif

endmodule

// File: rtl/ysyx_22051013_ifu.sv
// ----------------------------------------------------------------------------
// ysyx_22051013_ifu
//
// Purpose: instruction-fetch stage of the five-stage RV64 pipeline. Holds the
// fetch PC, issues one instruction-memory request at a time, predecodes the
// returned word (ysyx_22051013_ifu_predecode) and presents one instruction per
// handshake to decode. Redirects from decode squash the wrong-path fetch.
//
// Optional feature macro: YSYX_22051013_BPU_EN (static backward-taken branch
// prediction inside the predecoder).
//
// Parameters:
//   RESET_PC          first fetch address after reset
//
// Ports:
//   clk               in  1   core clock
//   rst               in  1   asynchronous reset, active-low
//   imem_req_valid    out 1   fetch request valid (decoded from state)
//   imem_req_ready    in  1   memory accepts the request
//   imem_req_addr     out 64  fetch address, bits [1:0] always 0
//   imem_resp_valid   in  1   fetch data valid (ignored outside WAIT/DROP)
//   imem_resp_data    in  32  instruction word
//   jump_ena          in  1   redirect from decode
//   jump_pc           in  64  redirect target (bits [1:0] forced to 0)
//   id_stall          in  1   decode cannot accept; hold outputs
//   inst_o            out 32  fetched instruction
//   pc_o              out 64  PC of inst_o
//   if_valid          out 1   inst_o / pc_o are valid
//   bpu_jump          out 1   inst_o is a branch predicted taken
// ----------------------------------------------------------------------------
module ysyx_22051013_ifu
    import ysyx_22051013_ifu_pkg::*;
#(
    parameter logic [63:0] RESET_PC = IFU_RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        jump_ena,
    input  logic [63:0] jump_pc,
    input  logic        id_stall,
    output logic [31:0] inst_o,
    output logic [63:0] pc_o,
    output logic        if_valid,
    output logic        bpu_jump
);

    ifu_state_e  state_q,    state_d;
    logic [63:0] fetch_pc_q, fetch_pc_d;   // address of the current / next request
    logic [63:0] pred_pc_q,  pred_pc_d;    // predicted successor of inst_o
    logic [31:0] inst_q,     inst_d;
    logic [63:0] pc_q,       pc_d;
    logic        if_valid_q, if_valid_d;
    logic        bpu_jump_q, bpu_jump_d;

    logic [63:0] jump_pc_aligned;
    logic [63:0] pd_next_pc;
    logic        pd_bpu_jump;

    assign jump_pc_aligned = align_pc(jump_pc);

    // Predecode works on the word as it arrives, so the prediction is
    // registered together with the instruction.
    ysyx_22051013_ifu_predecode u_predecode (
        .inst     (imem_resp_data),
        .pc       (fetch_pc_q),
        .next_pc  (pd_next_pc),
        .bpu_jump (pd_bpu_jump)
    );

    // ------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pred_pc_d  = pred_pc_q;
        inst_d     = inst_q;
        pc_d       = pc_q;
        if_valid_d = if_valid_q;
        bpu_jump_d = bpu_jump_q;

        case (state_q)
            ST_RST: begin
                state_d = ST_REQ;
            end

            ST_REQ: begin
                // A redirect before acceptance simply retargets the request.
                // If the old address is accepted in the same cycle, its
                // response is still coming and must be dropped.
                if (jump_ena) begin
                    fetch_pc_d = jump_pc_aligned;
                end
                if (imem_req_ready) begin
                    state_d = jump_ena ? ST_DROP : ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (imem_resp_valid) begin
                    if (jump_ena) begin
                        // Response arrives together with the redirect: it is
                        // wrong-path, nothing is outstanding any more.
                        fetch_pc_d = jump_pc_aligned;
                        state_d    = ST_REQ;
                    end else begin
                        inst_d     = imem_resp_data;
                        pc_d       = fetch_pc_q;
                        pred_pc_d  = pd_next_pc;
                        bpu_jump_d = pd_bpu_jump;
                        if_valid_d = 1'b1;
                        state_d    = ST_VALID;
                    end
                end else if (jump_ena) begin
                    fetch_pc_d = jump_pc_aligned;
                    state_d    = ST_DROP;
                end
            end

            ST_DROP: begin
                // fetch_pc_q already holds the redirect target; later
                // redirects override it.
                if (jump_ena) begin
                    fetch_pc_d = jump_pc_aligned;
                end
                if (imem_resp_valid) begin
                    state_d = ST_REQ;
                end
            end

            ST_VALID: begin
                // The redirect wins over a stall: the held instruction is
                // wrong-path anyway.
                if (jump_ena) begin
                    if_valid_d = 1'b0;
                    fetch_pc_d = jump_pc_aligned;
                    state_d    = ST_REQ;
                end else if (!id_stall) begin
                    if_valid_d = 1'b0;
                    fetch_pc_d = pred_pc_q;
                    state_d    = ST_REQ;
                end
            end

            default: begin
                state_d = ST_RST;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RST;
            fetch_pc_q <= align_pc(RESET_PC);
            pred_pc_q  <= '0;
            inst_q     <= '0;
            pc_q       <= '0;
            if_valid_q <= 1'b0;
            bpu_jump_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pred_pc_q  <= pred_pc_d;
            inst_q     <= inst_d;
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            bpu_jump_q <= bpu_jump_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign imem_req_valid = (state_q == ST_REQ);
    assign imem_req_addr  = fetch_pc_q;
    assign inst_o         = inst_q;
    assign pc_o           = pc_q;
    assign if_valid       = if_valid_q;
    assign bpu_jump       = bpu_jump_q;

endmodule

// File: tb/tb_ysyx_22051013_ifu.sv
// ----------------------------------------------------------------------------
// tb_ysyx_22051013_ifu
//
// Directed bench for ysyx_22051013_ifu. Expected request addresses and
// expected delivered instructions are queued when stimulus is driven and
// popped when the fetch unit produces them. Branch expectations depend on
// YSYX_22051013_BPU_EN.
// ----------------------------------------------------------------------------
module tb_ysyx_22051013_ifu;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
        logic        bpu;
    } out_t;

    localparam logic [31:0] ADDI = 32'h0010_0093;   // addi x1, x0, 1

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        jump_ena;
    logic [63:0] jump_pc;
    logic        id_stall;
    logic [31:0] inst_o;
    logic [63:0] pc_o;
    logic        if_valid;
    logic        bpu_jump;

    int   n_cmp  = 0;
    int   n_fail = 0;
    logic [63:0] req_q[$];
    out_t        out_q[$];
    out_t        cur;

    ysyx_22051013_ifu dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .jump_ena        (jump_ena),
        .jump_pc         (jump_pc),
        .id_stall        (id_stall),
        .inst_o          (inst_o),
        .pc_o            (pc_o),
        .if_valid        (if_valid),
        .bpu_jump        (bpu_jump)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] enc_jal(input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd0, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_beq(input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd0, 5'd0, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a request, compare its address with the queue head,
    // and optionally accept it.
    task automatic wait_req(input bit accept);
        logic [63:0] exp_addr;
        int n;
        n = 0;
        while (!imem_req_valid && n < 20) begin
            step();
            n++;
        end
        check("req_valid", 64'(imem_req_valid), 64'd1);
        exp_addr = req_q.pop_front();
        check("req_addr", imem_req_addr, exp_addr);
        $display("req  addr=%h expected=%h accept=%0d", imem_req_addr, exp_addr, accept);
        if (accept) begin
            imem_req_ready = 1'b1;
            step();
            imem_req_ready = 1'b0;
        end
    endtask

    // Return one word (from WAIT) and check what is presented to decode.
    task automatic respond(input logic [31:0] inst, input logic [63:0] pc, input logic bpu);
        out_t e;
        e.inst = inst;
        e.pc   = pc;
        e.bpu  = bpu;
        out_q.push_back(e);
        imem_resp_valid = 1'b1;
        imem_resp_data  = inst;
        step();
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        cur = out_q.pop_front();
        check("if_valid", 64'(if_valid), 64'd1);
        check("inst_o", 64'(inst_o), 64'(cur.inst));
        check("pc_o", pc_o, cur.pc);
        check("bpu_jump", 64'(bpu_jump), 64'(cur.bpu));
        $display("inst pc=%h inst=%h bpu=%0d", pc_o, inst_o, bpu_jump);
    endtask

    // Let decode stall for some cycles, then consume; the next request
    // address is queued here.
    task automatic consume(input logic [63:0] next_addr, input int stall);
        req_q.push_back(next_addr);
        for (int i = 0; i < stall; i++) begin
            id_stall = 1'b1;
            step();
            check("stall_valid", 64'(if_valid), 64'd1);
            check("stall_pc", pc_o, cur.pc);
            check("stall_inst", 64'(inst_o), 64'(cur.inst));
            check("stall_noreq", 64'(imem_req_valid), 64'd0);
        end
        id_stall = 1'b0;
        step();
        check("consumed_valid", 64'(if_valid), 64'd0);
    endtask

    initial begin
        logic [63:0] beq_next;
        logic        beq_bpu;
`ifdef YSYX_22051013_BPU_EN
        beq_next = 64'h0000_0000_8000_0038;
        beq_bpu  = 1'b1;
`else
        beq_next = 64'h0000_0000_8000_0044;
        beq_bpu  = 1'b0;
`endif
        rst             = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        jump_ena        = 1'b0;
        jump_pc         = '0;
        id_stall        = 1'b0;

        // Reset values
        step();
        step();
        check("rst_req_valid", 64'(imem_req_valid), 64'd0);
        check("rst_inst_o", 64'(inst_o), 64'd0);
        check("rst_pc_o", pc_o, 64'd0);
        check("rst_if_valid", 64'(if_valid), 64'd0);
        check("rst_bpu_jump", 64'(bpu_jump), 64'd0);
        rst = 1'b1;

        // Straight-line fetch, JAL chain, and a backward BEQ held by a stall
        req_q.push_back(64'h0000_0000_8000_0000);
        wait_req(1'b1);
        respond(ADDI, 64'h0000_0000_8000_0000, 1'b0);
        consume(64'h0000_0000_8000_0004, 0);
        wait_req(1'b1);
        respond(enc_jal(21'h0000C), 64'h0000_0000_8000_0004, 1'b0);
        consume(64'h0000_0000_8000_0010, 0);
        wait_req(1'b1);
        respond(enc_jal(21'h00020), 64'h0000_0000_8000_0010, 1'b0);
        consume(64'h0000_0000_8000_0030, 0);
        wait_req(1'b1);
        respond(enc_jal(21'h00010), 64'h0000_0000_8000_0030, 1'b0);
        consume(64'h0000_0000_8000_0040, 0);
        wait_req(1'b1);
        respond(enc_beq(13'h1FF8), 64'h0000_0000_8000_0040, beq_bpu);
        consume(beq_next, 4);

        // Redirect while in WAIT (target has low bits set): response dropped
        wait_req(1'b1);
        jump_ena = 1'b1;
        jump_pc  = 64'h0000_0000_8000_0102;
        step();
        jump_ena = 1'b0;
        check("drop_if_valid", 64'(if_valid), 64'd0);
        check("drop_noreq", 64'(imem_req_valid), 64'd0);
        imem_resp_valid = 1'b1;
        imem_resp_data  = ADDI;
        req_q.push_back(64'h0000_0000_8000_0100);
        step();
        imem_resp_valid = 1'b0;
        check("drop_resp_ignored", 64'(if_valid), 64'd0);
        wait_req(1'b1);

        // Redirect and stall together in VALID: redirect wins
        respond(ADDI, 64'h0000_0000_8000_0100, 1'b0);
        id_stall = 1'b1;
        jump_ena = 1'b1;
        jump_pc  = 64'h0000_0000_8000_0200;
        req_q.push_back(64'h0000_0000_8000_0200);
        step();
        jump_ena = 1'b0;
        id_stall = 1'b0;
        check("jump_stall_if_valid", 64'(if_valid), 64'd0);
        wait_req(1'b1);

        // Reset during WAIT, late response ignored
        rst = 1'b0;
        #1;
        check("rst2_req_valid", 64'(imem_req_valid), 64'd0);
        check("rst2_if_valid", 64'(if_valid), 64'd0);
        check("rst2_inst_o", 64'(inst_o), 64'd0);
        check("rst2_pc_o", pc_o, 64'd0);
        check("rst2_bpu_jump", 64'(bpu_jump), 64'd0);
        imem_resp_valid = 1'b1;
        imem_resp_data  = enc_jal(21'h00100);
        step();
        rst = 1'b1;
        step();
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        check("late_resp_ignored", 64'(if_valid), 64'd0);

        // Redirect in REQ before acceptance retargets the request
        req_q.push_back(64'h0000_0000_8000_0000);
        wait_req(1'b0);
        jump_ena = 1'b1;
        jump_pc  = 64'h0000_0000_8000_0300;
        req_q.push_back(64'h0000_0000_8000_0300);
        step();
        jump_ena = 1'b0;
        wait_req(1'b1);
        respond(ADDI, 64'h0000_0000_8000_0300, 1'b0);
        consume(64'h0000_0000_8000_0304, 0);
        wait_req(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
